// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bi, LSB first, through one full-subtractor cell and a borrow FF.
// Result valid WIDTH edges after accept; in_ready only in IDLE, and DONE holds until out_ready.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
    logic             br, br_nxt, d_bit, last;
    logic [CW-1:0]    cnt;

    // Full-subtractor cell; res_nxt already carries this edge's difference bit in its MSB.
    always_comb begin
        d_bit            = op_a[0] ^ op_b[0] ^ br;
        br_nxt           = (~op_a[0] & op_b[0]) | (~(op_a[0] ^ op_b[0]) & br);
        res_nxt          = res >> 1;
        res_nxt[WIDTH-1] = d_bit;
    end

    assign last = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            D    <= '0;
            Bo   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= A;
                        op_b <= B;
                        br   <= Bi;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    op_a <= op_a >> 1;
                    op_b <= op_b >> 1;
                    br   <= br_nxt;
                    res  <= res_nxt;
                    cnt  <= cnt + CW'(1);
                    // D/Bo only update at completion so they hold across DONE->IDLE
                    if (last) begin
                        D  <= res_nxt;
                        Bo <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 (directed) and 1/8/16 (random).
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   rand_go;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Directed WIDTH=8 instance
    logic       d_in_valid, d_in_ready, d_bi, d_out_valid, d_out_ready, d_bo, d_busy;
    logic [7:0] d_a, d_b, d_d;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .A         (d_a),
        .B         (d_b),
        .Bi        (d_bi),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .D         (d_d),
        .Bo        (d_bo),
        .busy      (d_busy)
    );

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int t;
        t = 0;
        d_a = a; d_b = b; d_bi = bi; d_in_valid = 1'b1;
        while (!d_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_rdy", d_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        d_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [7:0] exp_d, input logic exp_bo);
        int lat;
        lat = 0;
        while (!d_out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, lat, 8);
        check({tag, "_d"}, d_d, exp_d);
        check({tag, "_bo"}, d_bo, exp_bo);
        check({tag, "_rdy"}, d_in_ready, 0);
        check({tag, "_busy"}, d_busy, 1);
    endtask

    task automatic take(input logic [7:0] exp_d);
        d_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_out_ready = 1'b0;
        check("take_vld", d_out_valid, 0);
        check("take_rdy", d_in_ready, 1);
        check("take_busy", d_busy, 0);
        check("take_hold_d", d_d, exp_d);
    endtask

    // Randomized instances at WIDTH = 1, 8, 16
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 8 : 16);
        localparam int N = 340;
        logic         r_in_valid, r_in_ready, r_bi, r_out_valid, r_out_ready, r_bo, r_busy;
        logic [W-1:0] r_a, r_b, r_d;
        bit           done_flag;

        serial_subtractor #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (r_in_valid),
            .in_ready  (r_in_ready),
            .A         (r_a),
            .B         (r_b),
            .Bi        (r_bi),
            .out_valid (r_out_valid),
            .out_ready (r_out_ready),
            .D         (r_d),
            .Bo        (r_bo),
            .busy      (r_busy)
        );

        initial begin
            logic [31:0] expq[$];
            logic [31:0] rmask;
            int sent, got, guard, acc_cyc, diff;
            bit prev_vld, acc_flag;
            sent = 0; got = 0; guard = 0; acc_cyc = 0; prev_vld = 0; acc_flag = 0;
            rmask = (32'd1 << (W + 1)) - 32'd1;
            done_flag = 0;
            r_in_valid = 0; r_out_ready = 0; r_a = '0; r_b = '0; r_bi = 0;
            wait (rand_go);
            while (got < N && guard < 40000) begin
                @(negedge clk);
                guard++;
                if (r_out_valid && !prev_vld)
                    check($sformatf("lat_w%0d", W), 32'(cyc - acc_cyc), W);
                prev_vld = r_out_valid;
                if (acc_flag) begin
                    r_in_valid = 0;
                    acc_flag = 0;
                end
                if (!r_in_valid && sent < N && $urandom_range(0, 3) != 0) begin
                    r_a  = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    r_b  = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    r_bi = 1'($urandom);
                    r_in_valid = 1;
                end
                if (r_in_valid && r_in_ready) begin
                    diff = int'(r_a) - int'(r_b) - int'(r_bi);
                    expq.push_back(32'(diff) & rmask);
                    acc_cyc = cyc + 1;
                    sent++;
                    acc_flag = 1;
                end
                r_out_ready = ($urandom_range(0, 2) != 0);
                if (r_out_valid && r_out_ready) begin
                    check($sformatf("nodup_w%0d", W), 32'(expq.size() != 0), 1);
                    if (expq.size() != 0)
                        check($sformatf("res_w%0d_op%0d", W, got), {r_bo, r_d}, expq.pop_front());
                    got++;
                end
            end
            @(negedge clk);
            r_out_ready = 0;
            r_in_valid = 0;
            check($sformatf("count_w%0d", W), got, N);
            check($sformatf("sent_w%0d", W), sent, N);
            check($sformatf("drain_w%0d", W), expq.size(), 0);
            done_flag = 1;
        end
    end

    initial begin
        int t;
        n_checks = 0; n_errors = 0; rand_go = 0; cyc = 0;
        rst_n = 1'b0;
        d_in_valid = 0; d_out_ready = 0; d_a = '0; d_b = '0; d_bi = 0;
        @(negedge clk);
        d_in_valid = 1'b1;
        @(negedge clk);
        check("rst_rdy", d_in_ready, 1);
        check("rst_vld", d_out_valid, 0);
        check("rst_busy", d_busy, 0);
        check("rst_d", d_d, 0);
        check("rst_bo", d_bo, 0);
        d_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h5A, 8'h3C, 1'b0); wait_done("t1", 8'h1E, 1'b0); take(8'h1E);
        issue(8'h00, 8'h01, 1'b0); wait_done("t2", 8'hFF, 1'b1); take(8'hFF);
        issue(8'h10, 8'h10, 1'b1); wait_done("t3a", 8'hFF, 1'b1); take(8'hFF);
        issue(8'hFF, 8'h00, 1'b1); wait_done("t3b", 8'hFE, 1'b0); take(8'hFE);

        // Stalled DONE with a new request pending
        issue(8'h5A, 8'h3C, 1'b0); wait_done("t4", 8'h1E, 1'b0);
        d_a = 8'h33; d_b = 8'h11; d_bi = 1'b0; d_in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_vld", d_out_valid, 1);
            check("t4_hold_d", d_d, 8'h1E);
            check("t4_hold_bo", d_bo, 0);
            check("t4_hold_rdy", d_in_ready, 0);
        end
        d_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_out_ready = 1'b0;
        check("t4_idle_rdy", d_in_ready, 1);
        check("t4_idle_d", d_d, 8'h1E);
        issue(8'h33, 8'h11, 1'b0); wait_done("t4_new", 8'h22, 1'b0); take(8'h22);

        // Reset in the third SHIFT cycle
        issue(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_vld", d_out_valid, 0);
        check("t5_rdy", d_in_ready, 1);
        check("t5_d", d_d, 0);
        check("t5_busy", d_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while in DONE drops out_valid at once
        issue(8'h44, 8'h01, 1'b0); wait_done("t5_done", 8'h43, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("t5_done_vld", d_out_valid, 0);
        check("t5_done_d", d_d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h80, 8'h7F, 1'b0); wait_done("t5_after", 8'h01, 1'b0); take(8'h01);

        rand_go = 1;
        t = 0;
        while (!(g_rnd[0].done_flag && g_rnd[1].done_flag && g_rnd[2].done_flag) && t < 50000) begin
            @(negedge clk);
            t++;
        end
        check("rand_done", 32'(g_rnd[0].done_flag && g_rnd[1].done_flag && g_rnd[2].done_flag), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
